// File: rtl/reg_shift_sequencer_pkg.sv
// Shared encodings for the register-file shift sequencer.
package reg_shift_pkg;

    // Shift operation selected by the op input
    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_shift_sequencer_shift_step.sv
// Combinational single-bit shift/rotate of a WIDTH-bit word.
module shift_step
    import reg_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // One-position shift selected by op
    always_comb begin
        dout = din;
        case (op)
            OP_LSL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_LSR:  dout = {1'b0, din[WIDTH-1:1]};
            OP_ASR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Read-modify-write sequencer: reads one register, shifts it one bit per
// cycle, and writes the result back through the register-file write port.
module reg_shift_sequencer
    import reg_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 3,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [SHW-1:0]   amount,
    output logic [AW-1:0]    rf_rAddr,
    input  logic [WIDTH-1:0] rf_rData,
    output logic [AW-1:0]    rf_wAddr,
    output logic [WIDTH-1:0] rf_wData,
    output logic             rf_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state;
    op_t              op_q;
    logic [AW-1:0]    dst_q;
    logic [SHW-1:0]   amt_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] step_out;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op   (op_q),
        .din  (shreg),
        .dout (step_out)
    );

    // FSM with latched request fields; rf_rAddr doubles as the latched source
    // address, and rf_we/busy/done are registered alongside the state so they
    // depend on state only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= OP_LSL;
            dst_q    <= '0;
            amt_q    <= '0;
            cnt      <= '0;
            shreg    <= '0;
            rf_rAddr <= '0;
            rf_wAddr <= '0;
            rf_wData <= '0;
            rf_we    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op_t'(op);
                        rf_rAddr <= src_addr;
                        dst_q    <= dst_addr;
                        amt_q    <= amount;
                        busy     <= 1'b1;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    shreg <= rf_rData;
                    cnt   <= amt_q;
                    if (amt_q == '0) begin
                        rf_we    <= 1'b1;
                        rf_wAddr <= dst_q;
                        rf_wData <= rf_rData;
                        state    <= S_WRITE;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= step_out;
                    cnt   <= cnt - SHW'(1);
                    // Write data is taken from the final step directly so the
                    // write lands in the cycle right after the last shift.
                    if (cnt == SHW'(1)) begin
                        rf_we    <= 1'b1;
                        rf_wAddr <= dst_q;
                        rf_wData <= step_out;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    rf_we  <= 1'b0;
                    result <= rf_wData;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    rf_we <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
